svcs_trnx_framer: RTL

SVCS_TRNX_FRAMER -- requirements
Module: svcs_trnx_framer

---
 rtl/svcs_trnx_pkg.sv | 33 +++
 rtl/svcs_sync_fifo.sv | 68 ++++++
 rtl/svcs_trnx_framer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/svcs_trnx_pkg.sv
// ============================================================================
// Module : svcs_trnx_pkg
// Brief  : Shared header layout, framer FSM states and constants for the
//          transaction framer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package svcs_trnx_pkg;

    localparam int SVCS_HDR_WORDS = 4;

    typedef enum logic [2:0] {
        ST_COLLECT   = 3'd0,
        ST_HDR_TYPE  = 3'd1,
        ST_HDR_ID    = 3'd2,
        ST_HDR_DTYPE = 3'd3,
        ST_HDR_NPL   = 3'd4,
        ST_PAYLOAD   = 3'd5,
        ST_CSUM      = 3'd6
    } svcs_state_e;

    // Header fields travel in the order they are declared here.
    typedef struct packed {
        logic [31:0] trnx_type;
        logic [31:0] trnx_id;
        logic [31:0] data_type;
        logic [31:0] n_payloads;
    } svcs_hdr_t;

endpackage

`default_nettype wire

// File: rtl/svcs_sync_fifo.sv
// ============================================================================
// Module : svcs_sync_fifo
// Brief  : Single-clock FIFO with show-ahead read data and synchronous clear.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module svcs_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic [DATA_W-1:0]          din,
    input  logic                       pop,
    output logic [DATA_W-1:0]          dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_aw = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_aw:0]     r_count;

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + (c_aw+1)'(1);
                2'b01:   r_count <= r_count - (c_aw+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign empty = (r_count == '0);
    assign full  = (r_count == (c_aw+1)'(DEPTH));

endmodule

`default_nettype wire

// File: rtl/svcs_trnx_framer.sv
// ============================================================================
// Module : svcs_trnx_framer
// Brief  : Buffers one payload frame, then emits a 4-word header followed by
//          the payloads. Define SVCS_FRAMER_CHECKSUM_EN to append an XOR word.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module svcs_trnx_framer
    import svcs_trnx_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int MAX_PAYLOADS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] trnx_type_i,
    input  logic [DATA_W-1:0] data_type_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof,
    output logic              out_eof,
    output logic [31:0]       trnx_id_o,
    output logic              trunc_o
);

    localparam int c_cnt_w = $clog2(MAX_PAYLOADS) + 1;

    svcs_state_e r_state;
    svcs_state_e w_next_state;

    logic [31:0]        r_trnx_type;
    logic [31:0]        r_data_type;
    logic [31:0]        r_trnx_id;
    logic [31:0]        r_n_pl;
    svcs_hdr_t          w_hdr;

    logic               w_push;
    logic               w_pop;
    logic               w_out_xfer;
    logic               w_eof_xfer;
    logic               w_at_max;
    logic               w_close;
    logic               w_last_pl;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [DATA_W-1:0]  w_fifo_dout;
    logic [c_cnt_w-1:0] w_fifo_count;

    assign w_hdr = '{trnx_type:  r_trnx_type,
                     trnx_id:    r_trnx_id,
                     data_type:  r_data_type,
                     n_payloads: r_n_pl};

    assign w_push     = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;
    assign w_eof_xfer = w_out_xfer && out_eof;
    assign w_pop      = w_out_xfer && (r_state == ST_PAYLOAD);
    assign w_at_max   = (r_n_pl == 32'(MAX_PAYLOADS - 1));
    assign w_close    = w_push && (in_last || w_at_max);
    assign w_last_pl  = (w_fifo_count == c_cnt_w'(1));
    // A beat that carries in_last is a normal close, not a truncation.
    assign trunc_o    = w_push && w_at_max && !in_last;
    assign trnx_id_o  = r_trnx_id;

    svcs_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_PAYLOADS)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_eof_xfer),
        .push  (w_push),
        .din   (in_data),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_COLLECT:   if (w_close)    w_next_state = ST_HDR_TYPE;
            ST_HDR_TYPE:  if (w_out_xfer) w_next_state = ST_HDR_ID;
            ST_HDR_ID:    if (w_out_xfer) w_next_state = ST_HDR_DTYPE;
            ST_HDR_DTYPE: if (w_out_xfer) w_next_state = ST_HDR_NPL;
            ST_HDR_NPL:   if (w_out_xfer) w_next_state = ST_PAYLOAD;
`ifdef SVCS_FRAMER_CHECKSUM_EN
            ST_PAYLOAD:   if (w_out_xfer && w_last_pl) w_next_state = ST_CSUM;
            ST_CSUM:      if (w_out_xfer) w_next_state = ST_COLLECT;
`else
            ST_PAYLOAD:   if (w_out_xfer && w_last_pl) w_next_state = ST_COLLECT;
`endif
            default:      w_next_state = ST_COLLECT;
        endcase
    end

`ifdef SVCS_FRAMER_CHECKSUM_EN
    logic [DATA_W-1:0] r_csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csum <= '0;
        end else if (w_eof_xfer) begin
            r_csum <= '0;
        end else if (w_push) begin
            r_csum <= r_csum ^ in_data;
        end
    end
`endif

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_sof   = 1'b0;
        out_eof   = 1'b0;
        case (r_state)
            ST_COLLECT: in_ready = !w_fifo_full;
            ST_HDR_TYPE: begin
                out_valid = 1'b1;
                out_sof   = 1'b1;
                out_data  = DATA_W'(w_hdr.trnx_type);
            end
            ST_HDR_ID: begin
                out_valid = 1'b1;
                out_data  = DATA_W'(w_hdr.trnx_id);
            end
            ST_HDR_DTYPE: begin
                out_valid = 1'b1;
                out_data  = DATA_W'(w_hdr.data_type);
            end
            ST_HDR_NPL: begin
                out_valid = 1'b1;
                out_data  = DATA_W'(w_hdr.n_payloads);
            end
            ST_PAYLOAD: begin
                out_valid = !w_fifo_empty;
                out_data  = w_fifo_empty ? '0 : w_fifo_dout;
`ifndef SVCS_FRAMER_CHECKSUM_EN
                out_eof   = w_last_pl;
`endif
            end
`ifdef SVCS_FRAMER_CHECKSUM_EN
            ST_CSUM: begin
                out_valid = 1'b1;
                out_eof   = 1'b1;
                out_data  = r_csum;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trnx_type <= '0;
            r_data_type <= '0;
            r_trnx_id   <= '0;
            r_n_pl      <= '0;
        end else if (w_eof_xfer) begin
            r_trnx_id   <= r_trnx_id + 32'd1;
            r_n_pl      <= '0;
        end else if (w_push) begin
            r_n_pl      <= r_n_pl + 32'd1;
            if (r_n_pl == '0) begin
                r_trnx_type <= 32'(trnx_type_i);
                r_data_type <= 32'(data_type_i);
            end
        end
    end

endmodule

`default_nettype wire
